mem_access: RTL and testbench

//  RV32I memory stage: consumes registered execute-stage outputs, issues loads/stores on a
//  req/ack data-memory bus, sign/zero-extends load data and registers the writeback result.

---
 rtl/mem_access_if.sv | 12 +
 rtl/mem_access.sv | 164 ++++++++++++++++
 tb/tb_mem_access.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// mem_access_if: request/acknowledge data-memory bus between the memory stage and data memory
interface mem_access_if #(parameter int XLEN = 32);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic            ack;
  logic [XLEN-1:0] rdata;
  modport master(output req, we, addr, wdata, be, input ack, rdata);
  modport slave(input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_access.sv
// mem_access: RV32I memory stage issuing loads/stores on a req/ack bus and registering writeback
module mem_access #(
  parameter int XLEN  = 32,
  parameter int XADDR = 5,
  parameter int OPLEN = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [OPLEN-1:0] i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [XADDR-1:0] i_rd_addr,
  input  logic             i_rd_wr_en,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_stall,
  input  logic             i_flush,
  mem_access_if.master     dmem,
  output logic [XLEN-1:0]  ow_rd_fwd,
  output logic [XADDR-1:0] ow_rd_addr_fwd,
  output logic             ow_rd_fwd_wr_en,
  output logic [OPLEN-1:0] or_opcode,
  output logic [XADDR-1:0] or_rd_addr,
  output logic             or_rd_wr_en,
  output logic [XLEN-1:0]  or_rd_data,
  output logic [XLEN-1:0]  or_pc,
  output logic             or_misaligned,
  output logic [XLEN-1:0]  or_misaligned_addr,
  output logic             or_stall
);
  localparam logic [OPLEN-1:0] L_OP = 'b0000011;
  localparam logic [OPLEN-1:0] S_OP = 'b0100011;
  localparam logic [OPLEN-1:0] I_OP = 'b0010011;
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  typedef struct packed {
    logic [OPLEN-1:0] op;
    logic [XADDR-1:0] rd;
    logic             wr;
    logic [XLEN-1:0]  data;
    logic [XLEN-1:0]  pc;
  } wb_t;
  typedef struct packed {
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
  } bus_t;
  typedef struct packed {
    logic [2:0]       f3;
    logic [1:0]       off;
    logic             we;
    logic [OPLEN-1:0] op;
    logic [XADDR-1:0] rd;
    logic             wr;
    logic [XLEN-1:0]  pc;
    logic             fl;
  } txn_t;
  state_t          state_q, state_d;
  wb_t             wb_q, wb_d, res_wb;
  bus_t            bus_q, bus_d;
  txn_t            txn_q, txn_d;
  logic [XLEN-1:0] buf_q, buf_d, maddr_q, maddr_d, ld_data, st_data;
  logic            mis_q, mis_d;
  logic [3:0]      st_be;
  logic [1:0]      a;
  logic            is_l, is_s, is_ls, rsv, mis, go;
  function automatic logic [XLEN-1:0] ld_ext(input logic [2:0] f, input logic [1:0] o, input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{o, 3'b000} +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    return f[1] ? w : f[0] ? {{16{h[15] & ~f[2]}}, h} : {{24{b[7] & ~f[2]}}, b};
  endfunction
  assign a     = i_alu_result[1:0];
  assign is_l  = i_opcode == L_OP;
  assign is_s  = i_opcode == S_OP;
  assign is_ls = is_l | is_s;
  assign rsv   = is_l ? (i_funct3 == 3'b011 || i_funct3[2:1] == 2'b11) : is_s && i_funct3 >= 3'b011;
  assign mis   = is_ls & ~rsv & (i_funct3[1:0] == 2'b01 ? a[0] : i_funct3[1:0] == 2'b10 ? |a : 1'b0);
  assign go    = is_ls & ~rsv & ~mis;
  assign st_be   = i_funct3[1:0] == 2'b00 ? 4'b0001 << a : i_funct3[0] ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_data = i_funct3[1:0] == 2'b00 ? {4{i_rs2_data[7:0]}} : i_funct3[0] ? {2{i_rs2_data[15:0]}} : i_rs2_data;
  assign ld_data = txn_q.we ? '0 : ld_ext(txn_q.f3, txn_q.off, dmem.rdata);
  assign res_wb  = '{op: txn_q.op, rd: txn_q.rd, wr: txn_q.wr & ~txn_q.fl & ~i_flush,
                     data: state_q == HOLD ? buf_q : ld_data, pc: txn_q.pc};
  assign ow_rd_fwd       = i_alu_result;
  assign ow_rd_addr_fwd  = i_rd_addr;
  assign ow_rd_fwd_wr_en = i_rd_wr_en & ~is_l & ~i_flush;
  assign dmem.req   = bus_q.req;
  assign dmem.we    = bus_q.we;
  assign dmem.addr  = bus_q.addr;
  assign dmem.wdata = bus_q.wdata;
  assign dmem.be    = bus_q.be;
  assign or_opcode          = wb_q.op;
  assign or_rd_addr         = wb_q.rd;
  assign or_rd_wr_en        = wb_q.wr;
  assign or_rd_data         = wb_q.data;
  assign or_pc              = wb_q.pc;
  assign or_misaligned      = mis_q;
  assign or_misaligned_addr = maddr_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      wb_q    <= '0;
      bus_q   <= '0;
      txn_q   <= '0;
      buf_q   <= '0;
      mis_q   <= 1'b0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      bus_q   <= bus_d;
      txn_q   <= txn_d;
      buf_q   <= buf_d;
      mis_q   <= mis_d;
      maddr_q <= maddr_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (!i_stall && !i_flush && go ? BUSY : IDLE)
            : state_q == BUSY ? (dmem.ack ? (i_stall ? HOLD : IDLE) : BUSY)
            : (i_stall ? HOLD : IDLE);
  end
  // reserved funct3 is excluded from the IDLE stall so a held instruction cannot deadlock
  always_comb begin
    wb_d     = wb_q;
    bus_d    = bus_q;
    txn_d    = txn_q;
    buf_d    = buf_q;
    mis_d    = 1'b0;
    maddr_d  = maddr_q;
    or_stall = 1'b0;
    if (state_q == IDLE) begin
      or_stall = go & ~i_flush;
      if (!i_stall) begin
        if (i_flush || rsv) wb_d = '{op: I_OP, default: '0};
        else if (mis) wb_d = '{op: i_opcode, rd: i_rd_addr, wr: 1'b0, data: '0, pc: i_pc};
        else if (!is_ls) wb_d = '{op: i_opcode, rd: i_rd_addr, wr: i_rd_wr_en, data: i_alu_result, pc: i_pc};
        mis_d   = mis & ~i_flush;
        maddr_d = mis && !i_flush ? i_alu_result : maddr_q;
        if (go && !i_flush) begin
          bus_d = '{req: 1'b1, we: is_s, addr: {i_alu_result[XLEN-1:2], 2'b00},
                    wdata: is_s ? st_data : '0, be: is_s ? st_be : 4'b0000};
          txn_d = '{f3: i_funct3, off: a, we: is_s, op: i_opcode, rd: i_rd_addr,
                    wr: i_rd_wr_en & is_l, pc: i_pc, fl: 1'b0};
        end
      end
    end else if (state_q == BUSY) begin
      or_stall = ~dmem.ack;
      txn_d.fl = txn_q.fl | i_flush;
      if (dmem.ack) begin
        bus_d.req = 1'b0;
        if (i_stall) buf_d = ld_data;
        else wb_d = res_wb;
      end
    end else begin
      or_stall = 1'b1;
      txn_d.fl = txn_q.fl | i_flush;
      if (!i_stall) wb_d = res_wb;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for the memory stage with a delayed-ack memory responder
module tb_mem_access;
  logic        clk = 1'b0, rst = 1'b1;
  logic [6:0]  i_opcode = '0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_alu_result = '0, i_rs2_data = '0, i_pc = '0;
  logic [4:0]  i_rd_addr = '0;
  logic        i_rd_wr_en = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
  logic [31:0] ow_rd_fwd, or_rd_data, or_pc, or_misaligned_addr;
  logic [4:0]  ow_rd_addr_fwd, or_rd_addr;
  logic [6:0]  or_opcode;
  logic        ow_rd_fwd_wr_en, or_rd_wr_en, or_misaligned, or_stall;
  int          n_chk = 0, n_err = 0, ack_dly = 0, cnt = 0;
  logic [31:0] mem_word = '0, last_data = '0;
  mem_access_if bus();
  mem_access dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_alu_result(i_alu_result), .i_rs2_data(i_rs2_data), .i_rd_addr(i_rd_addr),
    .i_rd_wr_en(i_rd_wr_en), .i_pc(i_pc), .i_stall(i_stall), .i_flush(i_flush),
    .dmem(bus.master), .ow_rd_fwd(ow_rd_fwd), .ow_rd_addr_fwd(ow_rd_addr_fwd),
    .ow_rd_fwd_wr_en(ow_rd_fwd_wr_en), .or_opcode(or_opcode), .or_rd_addr(or_rd_addr),
    .or_rd_wr_en(or_rd_wr_en), .or_rd_data(or_rd_data), .or_pc(or_pc),
    .or_misaligned(or_misaligned), .or_misaligned_addr(or_misaligned_addr), .or_stall(or_stall)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [31:0] alu, rs2; logic [4:0] rd; logic wen;
    logic [31:0] pc; int dly; logic [31:0] word; int fl;
    logic [6:0] e_op; logic [4:0] e_rd; logic e_wen; logic [31:0] e_data, e_pc; int e_cyc;
    logic e_mis; logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_wdata;
  } vec_t;
  typedef struct {
    logic [6:0] op; logic [4:0] rd; logic wen; logic [31:0] data, pc; logic mis; logic [31:0] maddr;
  } exp_t;
  exp_t sb[$];
  vec_t tv[16];
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  // memory model: ack after ack_dly cycles of an asserted request
  always @(negedge clk) begin
    if (rst || !bus.req) begin
      bus.ack = 1'b0;
      cnt = 0;
    end else begin
      bus.ack = cnt >= ack_dly;
      bus.rdata = mem_word;
      cnt++;
    end
  end
  task automatic exec(input vec_t v);
    int nreq, nst;
    exp_t e;
    i_opcode = v.op; i_funct3 = v.f3; i_alu_result = v.alu; i_rs2_data = v.rs2;
    i_rd_addr = v.rd; i_rd_wr_en = v.wen; i_pc = v.pc; i_flush = v.fl == 1; i_stall = 1'b0;
    ack_dly = v.dly; mem_word = v.word;
    sb.push_back('{v.e_op, v.e_rd, v.e_wen, v.e_data, v.e_pc, v.e_mis, v.e_addr});
    #1;
    chk("fwd_data", ow_rd_fwd, v.alu);
    chk("fwd_addr", 32'(ow_rd_addr_fwd), 32'(v.rd));
    chk("fwd_wen", 32'(ow_rd_fwd_wr_en), 32'(v.wen && v.op != 7'h03 && v.fl != 1));
    nreq = 0; nst = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (bus.req) begin
        nreq++;
        chk("bus_addr", bus.addr, v.e_addr);
        chk("bus_be", 32'(bus.be), 32'(v.e_be));
        chk("bus_we", 32'(bus.we), 32'(v.op == 7'h23));
        if (bus.we) chk("bus_wdata", bus.wdata, v.e_wdata);
        if (v.fl == 2) i_flush = 1'b1;
      end
      if (!or_stall) break;
      nst++;
    end
    chk("req_cycles", nreq, v.e_cyc);
    chk("stall_cycles", nst, v.e_cyc);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("wb_op", 32'(or_opcode), 32'(e.op));
    chk("wb_rd", 32'(or_rd_addr), 32'(e.rd));
    chk("wb_wen", 32'(or_rd_wr_en), 32'(e.wen));
    chk("wb_data", or_rd_data, e.data);
    chk("wb_pc", or_pc, e.pc);
    chk("mis_flag", 32'(or_misaligned), 32'(e.mis));
    if (e.mis) chk("mis_addr", or_misaligned_addr, e.maddr);
    last_data = e.data;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t e;
    tv[0]  = '{7'h33, 3'd0, 32'h55,   32'h0,        5'd5,  1'b1, 32'h100, 0, 32'h0,        0, 7'h33, 5'd5,  1'b1, 32'h55,       32'h100, 0, 1'b0, 32'h0,    4'h0, 32'h0};
    tv[1]  = '{7'h03, 3'd0, 32'h1003, 32'h0,        5'd6,  1'b1, 32'h104, 0, 32'h80FF1234, 0, 7'h03, 5'd6,  1'b1, 32'hFFFFFF80, 32'h104, 1, 1'b0, 32'h1000, 4'h0, 32'h0};
    tv[2]  = '{7'h03, 3'd4, 32'h1003, 32'h0,        5'd6,  1'b1, 32'h108, 0, 32'h80FF1234, 0, 7'h03, 5'd6,  1'b1, 32'h00000080, 32'h108, 1, 1'b0, 32'h1000, 4'h0, 32'h0};
    tv[3]  = '{7'h03, 3'd1, 32'h1002, 32'h0,        5'd7,  1'b1, 32'h10C, 0, 32'h80FF1234, 0, 7'h03, 5'd7,  1'b1, 32'hFFFF80FF, 32'h10C, 1, 1'b0, 32'h1000, 4'h0, 32'h0};
    tv[4]  = '{7'h03, 3'd5, 32'h1000, 32'h0,        5'd7,  1'b1, 32'h110, 0, 32'h80FF9234, 0, 7'h03, 5'd7,  1'b1, 32'h00009234, 32'h110, 1, 1'b0, 32'h1000, 4'h0, 32'h0};
    tv[5]  = '{7'h03, 3'd2, 32'h1004, 32'h0,        5'd8,  1'b1, 32'h114, 2, 32'h12345678, 0, 7'h03, 5'd8,  1'b1, 32'h12345678, 32'h114, 3, 1'b0, 32'h1004, 4'h0, 32'h0};
    tv[6]  = '{7'h23, 3'd1, 32'h2002, 32'hDEADBEEF, 5'd7,  1'b1, 32'h118, 0, 32'h0,        0, 7'h23, 5'd7,  1'b0, 32'h0,        32'h118, 1, 1'b0, 32'h2000, 4'hC, 32'hBEEFBEEF};
    tv[7]  = '{7'h23, 3'd0, 32'h2001, 32'h000000A5, 5'd0,  1'b0, 32'h11C, 1, 32'h0,        0, 7'h23, 5'd0,  1'b0, 32'h0,        32'h11C, 2, 1'b0, 32'h2000, 4'h2, 32'hA5A5A5A5};
    tv[8]  = '{7'h23, 3'd2, 32'h2004, 32'h01020304, 5'd0,  1'b0, 32'h120, 0, 32'h0,        0, 7'h23, 5'd0,  1'b0, 32'h0,        32'h120, 1, 1'b0, 32'h2004, 4'hF, 32'h01020304};
    tv[9]  = '{7'h03, 3'd2, 32'h1002, 32'h0,        5'd9,  1'b1, 32'h124, 0, 32'h0,        0, 7'h03, 5'd9,  1'b0, 32'h0,        32'h124, 0, 1'b1, 32'h1002, 4'h0, 32'h0};
    tv[10] = '{7'h33, 3'd0, 32'h77,   32'h0,        5'd9,  1'b1, 32'h128, 0, 32'h0,        0, 7'h33, 5'd9,  1'b1, 32'h77,       32'h128, 0, 1'b0, 32'h0,    4'h0, 32'h0};
    tv[11] = '{7'h03, 3'd0, 32'h1001, 32'h0,        5'd10, 1'b1, 32'h12C, 1, 32'h0000AB00, 2, 7'h03, 5'd10, 1'b0, 32'hFFFFFFAB, 32'h12C, 2, 1'b0, 32'h1000, 4'h0, 32'h0};
    tv[12] = '{7'h33, 3'd0, 32'h99,   32'h0,        5'd11, 1'b1, 32'h130, 0, 32'h0,        1, 7'h13, 5'd0,  1'b0, 32'h0,        32'h0,   0, 1'b0, 32'h0,    4'h0, 32'h0};
    tv[13] = '{7'h03, 3'd3, 32'h1000, 32'h0,        5'd12, 1'b1, 32'h134, 0, 32'h0,        0, 7'h13, 5'd0,  1'b0, 32'h0,        32'h0,   0, 1'b0, 32'h0,    4'h0, 32'h0};
    tv[14] = '{7'h03, 3'd1, 32'h1001, 32'h0,        5'd13, 1'b1, 32'h138, 0, 32'h0,        0, 7'h03, 5'd13, 1'b0, 32'h0,        32'h138, 0, 1'b1, 32'h1001, 4'h0, 32'h0};
    tv[15] = '{7'h33, 3'd0, 32'h42,   32'h0,        5'd3,  1'b1, 32'h13C, 0, 32'h0,        0, 7'h33, 5'd3,  1'b1, 32'h42,       32'h13C, 0, 1'b0, 32'h0,    4'h0, 32'h0};
    bus.ack = 1'b0;
    bus.rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op", 32'(or_opcode), 32'h0);
    chk("rst_wen", 32'(or_rd_wr_en), 32'h0);
    chk("rst_data", or_rd_data, 32'h0);
    chk("rst_req", 32'(bus.req), 32'h0);
    chk("rst_mis", 32'(or_misaligned), 32'h0);
    chk("rst_stall", 32'(or_stall), 32'h0);
    rst = 1'b0;
    foreach (tv[i]) exec(tv[i]);
    // ack under downstream stall: result buffered until the stall drops
    i_opcode = 7'h03; i_funct3 = 3'd2; i_alu_result = 32'h3000; i_rd_addr = 5'd10;
    i_rd_wr_en = 1'b1; i_pc = 32'h200; i_flush = 1'b0; i_stall = 1'b0;
    ack_dly = 0; mem_word = 32'hCAFEF00D;
    sb.push_back('{7'h03, 5'd10, 1'b1, 32'hCAFEF00D, 32'h200, 1'b0, 32'h0});
    @(posedge clk); #1;
    chk("hold_req_on", 32'(bus.req), 32'h1);
    i_stall = 1'b1;
    @(posedge clk); #1;
    chk("hold_req_off", 32'(bus.req), 32'h0);
    chk("hold_stall", 32'(or_stall), 32'h1);
    chk("hold_data_kept", or_rd_data, last_data);
    @(posedge clk); #1;
    chk("hold_data_kept2", or_rd_data, last_data);
    i_stall = 1'b0; i_opcode = 7'h13; i_rd_wr_en = 1'b0; i_rd_addr = '0; i_alu_result = '0;
    #1;
    chk("hold_stall_exit", 32'(or_stall), 32'h1);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("hold_wb_data", or_rd_data, e.data);
    chk("hold_wb_rd", 32'(or_rd_addr), 32'(e.rd));
    chk("hold_wb_wen", 32'(or_rd_wr_en), 32'(e.wen));
    chk("hold_idle_stall", 32'(or_stall), 32'h0);
    // reset in the middle of an outstanding transaction
    i_opcode = 7'h03; i_funct3 = 3'd2; i_alu_result = 32'h4000; i_rd_addr = 5'd4; i_rd_wr_en = 1'b1;
    ack_dly = 50;
    @(posedge clk); #1;
    chk("rstmid_req_on", 32'(bus.req), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_req_off", 32'(bus.req), 32'h0);
    chk("rstmid_data", or_rd_data, 32'h0);
    chk("rstmid_wen", 32'(or_rd_wr_en), 32'h0);
    rst = 1'b0; i_opcode = 7'h13; i_rd_wr_en = 1'b0; i_rd_addr = '0; i_alu_result = '0;
    #1;
    chk("rstmid_stall", 32'(or_stall), 32'h0);
    @(posedge clk); #1;
    chk("rstmid_idle_req", 32'(bus.req), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
